// File: rtl/fir_seq.sv
// Sequencer for the fir block: winds TAPS weights, loads TAPS data words, runs for
// run_len cycles and forwards run_len results. Strobes/results are 1 cycle behind their inputs.
module fir_seq #(
  parameter int TAPS    = 16,
  parameter int DW      = 16,
  parameter int RUN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RUN_W-1:0] run_len,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DW-1:0]    cfg_data,
  output logic             fir_wind,
  output logic             fir_load,
  output logic             fir_in_valid,
  output logic [DW-1:0]    fir_data,
  input  logic             fir_out_valid,
  input  logic [DW-1:0]    fir_out,
  output logic             res_valid,
  output logic [DW-1:0]    res_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(TAPS) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, WIND, LOAD, RUN, DRAIN} state_t;

  state_t           state;
  logic [CW-1:0]    word_cnt;
  logic [RUN_W-1:0] run_len_q;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] res_cnt;
  logic [TW-1:0]    idle_cnt;
  logic             accept;
  logic             counted;
  logic             res_full;

  assign cfg_ready = (state == WIND) || (state == LOAD);
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  // res_cnt never exceeds run_len_q, so the increment below cannot wrap
  assign counted   = fir_out_valid && ((state == RUN) || (state == DRAIN)) && (res_cnt != run_len_q);
  assign res_full  = ((res_cnt + {{(RUN_W-1){1'b0}}, counted}) == run_len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      run_len_q    <= '0;
      run_cnt      <= '0;
      res_cnt      <= '0;
      idle_cnt     <= '0;
      fir_wind     <= 1'b0;
      fir_load     <= 1'b0;
      fir_in_valid <= 1'b0;
      fir_data     <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      fir_wind     <= 1'b0;
      fir_load     <= 1'b0;
      fir_in_valid <= 1'b0;
      done         <= 1'b0;
      res_valid    <= counted;
      if (counted) begin
        res_data <= fir_out;
        res_cnt  <= res_cnt + 1'b1;
      end
      if ((state == DRAIN) && !fir_out_valid) idle_cnt <= idle_cnt + 1'b1;
      else                                    idle_cnt <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= WIND;
            run_len_q <= run_len;
            word_cnt  <= '0;
            run_cnt   <= '0;
            res_cnt   <= '0;
            err       <= 1'b0;
          end
        end
        WIND: begin
          if (accept) begin
            fir_data <= cfg_data;
            fir_wind <= 1'b1;
            if (word_cnt == CW'(TAPS - 1)) begin
              word_cnt <= '0;
              state    <= LOAD;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            fir_data <= cfg_data;
            fir_load <= 1'b1;
            if (word_cnt == CW'(TAPS - 1)) begin
              word_cnt <= '0;
              state    <= RUN;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          // a zero-length job still spends this cycle here so done trails the last load strobe
          if (run_len_q == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            fir_in_valid <= 1'b1;
            if (run_cnt == run_len_q - 1'b1) state   <= DRAIN;
            else                             run_cnt <= run_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (res_full) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (!fir_out_valid && (idle_cnt == TW'(TIMEOUT - 1))) begin
            state <= IDLE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq.sv
// Bench for fir_seq: table of jobs plus random jobs checked against a job-level model,
// with hand-written reset, abort, stray-start and stray-result sequences.
module tb_fir_seq;

  localparam int TAPS    = 16;
  localparam int DW      = 16;
  localparam int RUN_W   = 8;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 3;

  typedef struct {
    bit pat;
    int run_len;
    int gap_mode;
    int fir_limit;
    int exp_inval;
    int exp_res;
    bit exp_err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [RUN_W-1:0] run_len;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DW-1:0]    cfg_data;
  logic             fir_wind;
  logic             fir_load;
  logic             fir_in_valid;
  logic [DW-1:0]    fir_data;
  logic             fir_out_valid;
  logic [DW-1:0]    fir_out;
  logic             res_valid;
  logic [DW-1:0]    res_data;
  logic             busy;
  logic             done;
  logic             err;

  fir_seq #(.TAPS(TAPS), .DW(DW), .RUN_W(RUN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .run_len(run_len),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .fir_wind(fir_wind), .fir_load(fir_load), .fir_in_valid(fir_in_valid), .fir_data(fir_data),
    .fir_out_valid(fir_out_valid), .fir_out(fir_out),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- filter model: one result LAT cycles after each compute cycle
  int            fir_limit;
  bit            fir_inj;
  int            sent_cnt;
  int            last_sent_cyc;
  logic [DW-1:0] sent_q[$];
  bit            pipe[LAT];

  initial begin
    fir_out_valid = 1'b0;
    fir_out       = '0;
    sent_cnt      = 0;
    last_sent_cyc = 0;
    for (int i = 0; i < LAT; i++) pipe[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (start && !busy) begin
        sent_q.delete();
        sent_cnt = 0;
      end
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = fir_in_valid;
      fir_out_valid = 1'b0;
      if (fir_inj) begin
        fir_out_valid = 1'b1;
        fir_out       = DW'($urandom);
      end else if (pipe[LAT-1] && sent_cnt < fir_limit) begin
        fir_out_valid = 1'b1;
        fir_out       = DW'($urandom);
        sent_q.push_back(fir_out);
        sent_cnt++;
        last_sent_cyc = cyc;
      end
    end
  end

  // ---------------- output monitor
  logic [DW-1:0] obs_wind[$];
  logic [DW-1:0] obs_load[$];
  logic [DW-1:0] obs_res[$];
  int inval_cnt, inval_runs, first_inval, last_inval;
  int last_wind, first_load, last_load, done_cnt, done_cyc;
  int excl_err = 0;
  int hold_err = 0;
  int busy_done_err = 0;
  logic [DW-1:0] prev_data = '0;
  bit prev_inval = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (start && !busy) begin
        obs_wind.delete(); obs_load.delete(); obs_res.delete();
        inval_cnt = 0; inval_runs = 0; first_inval = -1; last_inval = -1;
        last_wind = -1; first_load = -1; last_load = -1; done_cnt = 0; done_cyc = -1;
      end
      if (!rst) begin
        if (int'(fir_wind) + int'(fir_load) + int'(fir_in_valid) > 1) excl_err++;
        if (!fir_wind && !fir_load && fir_data !== prev_data) hold_err++;
        if (fir_wind) begin obs_wind.push_back(fir_data); last_wind = cyc; end
        if (fir_load) begin
          obs_load.push_back(fir_data);
          if (first_load < 0) first_load = cyc;
          last_load = cyc;
        end
        if (fir_in_valid) begin
          inval_cnt++;
          if (!prev_inval) inval_runs++;
          if (first_inval < 0) first_inval = cyc;
          last_inval = cyc;
        end
        if (res_valid) obs_res.push_back(res_data);
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (busy) busy_done_err++;
        end
      end
      prev_data  = fir_data;
      prev_inval = fir_in_valid;
    end
  end

  function automatic int qmism(input logic [DW-1:0] a[$], input logic [DW-1:0] b[$]);
    int m = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) m++;
    return m;
  endfunction

  // ---------------- upstream driver
  logic [DW-1:0] feed_q[$];

  task automatic drive_cfg(input int gap_mode);
    int idx = 0;
    int n = 0;
    bit pres;
    while (idx < feed_q.size() && n < 2000) begin
      case (gap_mode)
        0:       pres = 1'b1;
        1:       pres = (n % 2 == 0);
        default: pres = ($urandom_range(0, 99) >= 30);
      endcase
      cfg_valid = pres;
      cfg_data  = pres ? feed_q[idx] : DW'($urandom);
      @(negedge clk);
      if (cfg_valid && cfg_ready) idx++;
      @(posedge clk); #1;
      n++;
    end
    cfg_valid = 1'b0;
    chk("words_accepted", idx, feed_q.size());
  endtask

  // ---------------- one job, compared against the job-level model
  task automatic run_job(input vec_t v, input bit tbl, input bit inj_start);
    logic [DW-1:0] w_exp[$];
    logic [DW-1:0] d_exp[$];
    logic [DW-1:0] r_exp[$];
    int rl = v.run_len;
    int n = 0;
    int d, f, exp_done, nres;
    bit exp_err;

    for (int i = 0; i < TAPS; i++) begin
      w_exp.push_back(v.pat ? DW'($urandom) : DW'(1));
      d_exp.push_back(v.pat ? DW'($urandom) : DW'(i + 1));
    end
    feed_q = {w_exp, d_exp};
    fir_limit = v.fir_limit;

    @(posedge clk); #1;
    chk("busy_before_start", busy, 0);
    start   = 1'b1;
    run_len = RUN_W'(rl);
    @(posedge clk); #1;
    start   = 1'b0;
    run_len = RUN_W'($urandom);
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", cfg_ready, 1);
    chk("err_clear_on_start", err, 0);

    drive_cfg(v.gap_mode);
    if (inj_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    while (done_cnt == 0 && n < 1500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", (done_cnt > 0), 1);
    repeat (6) @(posedge clk);
    #1;

    nres    = (sent_q.size() < rl) ? sent_q.size() : rl;
    exp_err = (sent_q.size() < rl);
    for (int i = 0; i < nres; i++) r_exp.push_back(sent_q[i]);
    d = last_load + rl;
    if (rl == 0)      exp_done = last_load + 1;
    else if (exp_err) begin
      f = (sent_q.size() > 0 && last_sent_cyc + 1 > d) ? last_sent_cyc + 1 : d;
      exp_done = f + TIMEOUT;
    end else          exp_done = ((last_sent_cyc > d) ? last_sent_cyc : d) + 1;

    chk("wind_count", obs_wind.size(), TAPS);
    chk("wind_words", qmism(obs_wind, w_exp), 0);
    chk("load_count", obs_load.size(), TAPS);
    chk("load_words", qmism(obs_load, d_exp), 0);
    chk("inval_cycles", inval_cnt, rl);
    chk("inval_runs", inval_runs, (rl > 0) ? 1 : 0);
    if (rl > 0) begin
      chk("inval_first", first_inval, last_load + 1);
      chk("inval_last", last_inval, last_load + rl);
    end
    chk("res_count", obs_res.size(), nres);
    chk("res_words", qmism(obs_res, r_exp), 0);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc, exp_done);
    chk("err_after_job", err, exp_err);
    chk("busy_after_job", busy, 0);
    if (v.gap_mode == 0) begin
      chk("wind_to_load_gap", first_load, last_wind + 1);
      chk("load_span", last_load - first_load, TAPS - 1);
    end
    if (tbl) begin
      chk("tbl_inval", inval_cnt, v.exp_inval);
      chk("tbl_res", obs_res.size(), v.exp_res);
      chk("tbl_err", err, v.exp_err);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {cfg_ready, fir_wind, fir_load, fir_in_valid, res_valid, busy, done, err}, 0);
    chk({tag, "_fir_data"}, fir_data, 0);
    chk({tag, "_res_data"}, res_data, 0);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   res_before;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0,   6, 0, 99,   6,   6, 0};
    tbl[1] = '{0,   6, 1, 99,   6,   6, 0};
    tbl[2] = '{1,   0, 0, 99,   0,   0, 0};
    tbl[3] = '{1,   6, 0,  3,   6,   3, 1};
    tbl[4] = '{1,   1, 2, 99,   1,   1, 0};
    tbl[5] = '{1,   9, 2,  0,   9,   0, 1};
    tbl[6] = '{1, 255, 0, 999, 255, 255, 0};
    tbl[7] = '{1,   4, 1, 99,   4,   4, 0};

    rst = 1'b1; start = 1'b0; run_len = '0; cfg_valid = 1'b0; cfg_data = '0;
    fir_inj = 1'b0; fir_limit = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("after_reset");

    for (int i = 0; i < 8; i++) run_job(tbl[i], 1'b1, 1'b0);

    // start pulsed during RUN must not restart or disturb the job
    run_job(tbl[0], 1'b1, 1'b1);

    // results arriving while idle are dropped
    res_before = obs_res.size();
    fir_inj = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    fir_inj = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_results_dropped", obs_res.size(), res_before);
    chk("idle_res_valid", res_valid, 0);
    chk("idle_busy", busy, 0);

    // reset in the middle of LOAD, then a fresh job must start from word 0
    feed_q.delete();
    for (int i = 0; i < TAPS + 5; i++) feed_q.push_back(DW'($urandom));
    @(posedge clk); #1;
    start = 1'b1; run_len = 8;
    @(posedge clk); #1;
    start = 1'b0;
    drive_cfg(0);
    chk("load_before_rst", fir_load, 1);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("mid_load_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_idle_busy", busy, 0);
    chk("rst_idle_ready", cfg_ready, 0);
    rv = '{1, 5, 0, 99, 5, 5, 0};
    run_job(rv, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rv.pat       = 1'b1;
      rv.run_len   = $urandom_range(0, 40);
      rv.gap_mode  = $urandom_range(0, 2);
      rv.fir_limit = ($urandom_range(0, 1) == 0) ? 999 : $urandom_range(0, rv.run_len);
      run_job(rv, 1'b0, 1'b0);
    end

    chk("strobes_exclusive", excl_err, 0);
    chk("fir_data_hold", hold_err, 0);
    chk("busy_low_with_done", busy_done_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
